// File: rtl/instruction_fetch.sv
// instruction_fetch: owns the program counter, addresses the instruction ROM
// and presents each fetched instruction to decode through a registered
// valid/ready output stage. Branch redirects flush the stage; fetching stops
// after the last program instruction has been handed over.
// Optional feature: define FETCH_STALL_COUNT_EN to add the 16-bit
// stall_cycles counter of cycles spent waiting on decode.
module instruction_fetch #(
  parameter int NUM_INSTR = 66,
  parameter int ADDR_W    = 7,
  parameter int INSTR_W   = 9
) (
  input  logic               clock,
  input  logic               reset_n,
  input  logic               start,
  output logic [ADDR_W-1:0]  rom_address,
  input  logic [INSTR_W-1:0] rom_instruction,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               instr_valid,
  input  logic               instr_ready,
  input  logic               branch_en,
  input  logic [ADDR_W-1:0]  branch_target,
  output logic               busy,
  output logic               done
`ifdef FETCH_STALL_COUNT_EN
  ,
  output logic [15:0]        stall_cycles
`endif
);

  // One past the last valid program address; the PC parks here at the end.
  localparam logic [ADDR_W-1:0] END_PC = ADDR_W'(NUM_INSTR);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state;
  state_t            next_state;
  logic [ADDR_W-1:0] pc;

  logic in_fetch;
  logic start_take;
  logic slot_free;
  logic load;
  logic accept;
  logic target_ok;
  logic at_end;

  // Decode the per-cycle decisions shared by the FSM and the datapath.
  always_comb begin
    in_fetch   = (state == FETCH);
    start_take = start && ((state == IDLE) || (state == DONE));
    slot_free  = !instr_valid || instr_ready;
    accept     = instr_valid && instr_ready;
    target_ok  = (branch_target < END_PC);
    at_end     = (pc == END_PC);
    load       = in_fetch && (pc < END_PC) && slot_free && !branch_en;
  end

  // State register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic: start launches a run, a branch out of range or
  // draining the last instruction ends it.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE: begin
        if (start) next_state = FETCH;
      end
      FETCH: begin
        if (branch_en) begin
          if (!target_ok) next_state = DONE;
        end else if (at_end && slot_free) begin
          next_state = DONE;
        end
      end
      DONE: begin
        if (start) next_state = FETCH;
      end
      default: next_state = IDLE;
    endcase
  end

  // PC and output stage: branch flushes, otherwise load when the stage is
  // free, otherwise drop the stage once decode takes it.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pc          <= '0;
      instr       <= '0;
      instr_pc    <= '0;
      instr_valid <= 1'b0;
    end else if (start_take) begin
      pc <= '0;
    end else if (in_fetch) begin
      if (branch_en) begin
        instr_valid <= 1'b0;
        if (target_ok) pc <= branch_target;
      end else if (load) begin
        instr       <= rom_instruction;
        instr_pc    <= pc;
        instr_valid <= 1'b1;
        pc          <= pc + ADDR_W'(1);
      end else if (accept) begin
        instr_valid <= 1'b0;
      end
    end
  end

`ifdef FETCH_STALL_COUNT_EN
  // Count FETCH cycles where decode holds off a valid instruction.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= '0;
    end else if (start_take) begin
      stall_cycles <= '0;
    end else if (in_fetch && instr_valid && !instr_ready && (stall_cycles != 16'hFFFF)) begin
      stall_cycles <= stall_cycles + 16'd1;
    end
  end
`endif

  assign rom_address = pc;
  assign busy        = (state == FETCH);
  assign done        = (state == DONE);

endmodule

// File: tb/tb_instruction_fetch.sv
// Testbench for instruction_fetch: random and directed stimulus compared
// every cycle against a transaction-level model of the fetch stage.
module tb_instruction_fetch;

  localparam int NUM_INSTR = 66;
  localparam int ADDR_W    = 7;
  localparam int INSTR_W   = 9;

  logic               clock = 1'b0;
  logic               reset_n = 1'b0;
  logic               start = 1'b0;
  logic [ADDR_W-1:0]  rom_address;
  logic [INSTR_W-1:0] rom_instruction;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               instr_valid;
  logic               instr_ready = 1'b0;
  logic               branch_en = 1'b0;
  logic [ADDR_W-1:0]  branch_target = '0;
  logic               busy;
  logic               done;
`ifdef FETCH_STALL_COUNT_EN
  logic [15:0]        stall_cycles;
`endif

  logic [INSTR_W-1:0] rom_mem [128];
  int checks = 0;
  int errors = 0;
  int acc_q[$];

  // Model of the fetch stage: run mode, next address to fetch, and the
  // address of the instruction currently presented to decode.
  int m_mode  = 0;
  int m_pc    = 0;
  bit m_valid = 1'b0;
  int m_ipc   = 0;
  int m_stall = 0;

  instruction_fetch #(
    .NUM_INSTR(NUM_INSTR),
    .ADDR_W(ADDR_W),
    .INSTR_W(INSTR_W)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .start(start),
    .rom_address(rom_address),
    .rom_instruction(rom_instruction),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .branch_en(branch_en),
    .branch_target(branch_target),
    .busy(busy),
    .done(done)
`ifdef FETCH_STALL_COUNT_EN
    ,
    .stall_cycles(stall_cycles)
`endif
  );

  // Combinational ROM.
  assign rom_instruction = rom_mem[rom_address];

  // Free-running clock.
  always #5 clock = ~clock;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic reportTimeout(input string name);
    checks++;
    errors++;
    $display("[TB] FAIL %s: timed out waiting, got busy=%0d done=%0d expected progress", name, busy, done);
  endtask

  // Present inputs for the next rising edge, return just after it.
  task automatic applyStimulus(input bit s, input bit rdy, input bit br, input logic [ADDR_W-1:0] tgt);
    start         = s;
    instr_ready   = rdy;
    branch_en     = br;
    branch_target = tgt;
    @(posedge clock);
    #1;
  endtask

  task automatic runUntilPc(input int target);
    int n = 0;
    while (!(instr_valid && int'(instr_pc) == target) && n < 300) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      n++;
    end
    if (n >= 300) reportTimeout("wait_pc");
  endtask

  task automatic runUntilDone();
    int n = 0;
    while (!done && n < 400) begin
      applyStimulus(1'b0, 1'b1, 1'b0, '0);
      n++;
    end
    if (n >= 400) reportTimeout("wait_done");
  endtask

  // Advance the model one clock using the inputs decode and the host present.
  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      m_mode  = 0;
      m_pc    = 0;
      m_valid = 1'b0;
      m_ipc   = 0;
      m_stall = 0;
    end else if (m_mode != 1) begin
      if (start) begin
        m_mode  = 1;
        m_pc    = 0;
        m_stall = 0;
      end
    end else begin
      bit free;
      if (m_valid && !instr_ready && m_stall < 65535) m_stall++;
      free = !m_valid || instr_ready;
      if (branch_en) begin
        m_valid = 1'b0;
        if (int'(branch_target) < NUM_INSTR) m_pc = int'(branch_target);
        else m_mode = 2;
      end else if (free && m_pc < NUM_INSTR) begin
        m_valid = 1'b1;
        m_ipc   = m_pc;
        m_pc    = m_pc + 1;
      end else if (free) begin
        m_valid = 1'b0;
        m_mode  = 2;
      end
    end
  end

  // Compare DUT against the model mid-cycle, and log accepted instructions.
  always @(negedge clock) begin
    checkOutput("rom_address", 32'(rom_address), 32'(m_pc));
    checkOutput("instr_valid", 32'(instr_valid), 32'(m_valid));
    checkOutput("busy", 32'(busy), 32'(m_mode == 1));
    checkOutput("done", 32'(done), 32'(m_mode == 2));
    if (m_valid) begin
      checkOutput("instr_pc", 32'(instr_pc), 32'(m_ipc));
      checkOutput("instr", 32'(instr), 32'(rom_mem[m_ipc]));
    end
`ifdef FETCH_STALL_COUNT_EN
    checkOutput("stall_cycles", 32'(stall_cycles), 32'(m_stall));
`endif
    if (instr_valid && instr_ready) acc_q.push_back(int'(instr_pc));
  end

  initial begin
    bit order_ok;
    for (int i = 0; i < 128; i++) rom_mem[i] = INSTR_W'($urandom);

    // Reset values.
    #1;
    checkOutput("rst_rom_address", 32'(rom_address), 0);
    checkOutput("rst_instr", 32'(instr), 0);
    checkOutput("rst_instr_pc", 32'(instr_pc), 0);
    checkOutput("rst_valid", 32'(instr_valid), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_done", 32'(done), 0);
    #11;
    reset_n = 1'b1;

    // Start latency: FETCH at address 0, first instruction one edge later.
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("start_busy", 32'(busy), 1);
    checkOutput("start_valid", 32'(instr_valid), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("first_valid", 32'(instr_valid), 1);
    checkOutput("first_pc", 32'(instr_pc), 0);
    checkOutput("first_instr", 32'(instr), 32'(rom_mem[0]));
    checkOutput("first_rom_address", 32'(rom_address), 1);

    // Backpressure at instr_pc=10.
    runUntilPc(10);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b0, '0);
    checkOutput("stall_pc", 32'(instr_pc), 10);
    checkOutput("stall_valid", 32'(instr_valid), 1);
    checkOutput("stall_instr", 32'(instr), 32'(rom_mem[10]));
    checkOutput("stall_rom_address", 32'(rom_address), 11);
`ifdef FETCH_STALL_COUNT_EN
    checkOutput("stall_count", 32'(stall_cycles), 5);
`endif
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("after_stall_pc", 32'(instr_pc), 11);

    // Branch to 3 at instr_pc=20: one bubble, then 3, 4.
    runUntilPc(20);
    applyStimulus(1'b0, 1'b1, 1'b1, 7'd3);
    checkOutput("branch_bubble", 32'(instr_valid), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("branch_pc0", 32'(instr_pc), 3);
    checkOutput("branch_instr0", 32'(instr), 32'(rom_mem[3]));
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("branch_pc1", 32'(instr_pc), 4);

    // Random traffic: backpressure, branches (some out of range), stray starts.
    for (int i = 0; i < 600; i++) begin
      applyStimulus($urandom_range(99) < 5, $urandom_range(99) < 70,
                    $urandom_range(99) < 3, ADDR_W'($urandom_range(127)));
    end
    runUntilDone();

    // Straight-line run: every address exactly once, in order.
    acc_q.delete();
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    runUntilDone();
    checkOutput("run_count", 32'(acc_q.size()), 32'(NUM_INSTR));
    order_ok = 1'b1;
    foreach (acc_q[i]) if (acc_q[i] != i) order_ok = 1'b0;
    checkOutput("run_order", 32'(order_ok), 1);
    checkOutput("run_done", 32'(done), 1);
    checkOutput("run_end_valid", 32'(instr_valid), 0);

    // Branch out of range ends the run; a new start restarts at 0.
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    runUntilPc(5);
    applyStimulus(1'b0, 1'b1, 1'b1, 7'd100);
    checkOutput("oor_valid", 32'(instr_valid), 0);
    checkOutput("oor_done", 32'(done), 1);
    checkOutput("oor_busy", 32'(busy), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("restart_rom_address", 32'(rom_address), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("restart_pc", 32'(instr_pc), 0);
    checkOutput("restart_valid", 32'(instr_valid), 1);

    // Start ignored in FETCH, then asynchronous reset mid-run.
    runUntilPc(30);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    checkOutput("start_ignored_pc", 32'(instr_pc), 31);
    checkOutput("start_ignored_addr", 32'(rom_address), 32);
    start = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    checkOutput("arst_rom_address", 32'(rom_address), 0);
    checkOutput("arst_instr", 32'(instr), 0);
    checkOutput("arst_instr_pc", 32'(instr_pc), 0);
    checkOutput("arst_valid", 32'(instr_valid), 0);
    checkOutput("arst_busy", 32'(busy), 0);
    checkOutput("arst_done", 32'(done), 0);
`ifdef FETCH_STALL_COUNT_EN
    checkOutput("arst_stall", 32'(stall_cycles), 0);
`endif
    @(posedge clock);
    #3;
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("idle_busy", 32'(busy), 0);
    applyStimulus(1'b1, 1'b1, 1'b0, '0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);
    checkOutput("post_reset_pc", 32'(instr_pc), 0);
    applyStimulus(1'b0, 1'b1, 1'b0, '0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

- Fetch-side initiator for the instruction ROM: owns the program counter, drives the ROM's 7-bit address, and captures the returned 9-bit instruction into a registered output stage.
- Hands instructions to decode over a valid/ready handshake; accepts branch redirects and halts after the last program instruction.
- Sits between the instruction ROM and the decode stage.

## Interface
Parameters:
- NUM_INSTR, 66, program length in instructions; must satisfy NUM_INSTR < 2**ADDR_W
- ADDR_W, 7, ROM address width
- INSTR_W, 9, instruction width

Ports:
- clock  in  1  single clock, rising edge
- reset_n  in  1  reset, asynchronous, active-low
- start  in  1  begin fetching at address 0; sampled only in IDLE or DONE
- rom_address  out  ADDR_W  address to ROM; driven directly from the PC register
- rom_instruction  in  INSTR_W  combinational ROM data for rom_address
- instr  out  INSTR_W  registered instruction to decode
- instr_pc  out  ADDR_W  address instr was fetched from
- instr_valid  out  1  instr/instr_pc hold a valid instruction
- instr_ready  in  1  decode accepts the instruction this cycle
- branch_en  in  1  redirect request; honoured only in FETCH
- branch_target  in  ADDR_W  redirect address
- busy  out  1  high in FETCH
- done  out  1  high in DONE

## Operation
States are IDLE, FETCH and DONE.

- **IDLE:** start=1 -> pc<=0, go to FETCH.
- **FETCH, load condition:** load = (pc < NUM_INSTR) && (!instr_valid || instr_ready) && !branch_en. On load:
  - instr<=rom_instruction
  - instr_pc<=pc
  - instr_valid<=1
  - pc<=pc+1
- **FETCH, accept without load:** instr_valid && instr_ready && !load -> instr_valid<=0.
- **FETCH, branch (priority over load and accept):**
  - Flush the output stage: instr_valid<=0, whether or not instr_ready is high.
  - If branch_target < NUM_INSTR, pc<=branch_target and stay in FETCH.
  - Otherwise go to DONE.
- **FETCH, end of program:** pc == NUM_INSTR and (no valid instruction held, or the held one is accepted this cycle) -> go to DONE with instr_valid<=0.
- **DONE:** done=1. start=1 -> pc<=0, go to FETCH.
- **Ignored inputs:** start is ignored in FETCH. branch_en is ignored in IDLE and DONE.
- **PC arithmetic:** ADDR_W-bit unsigned. The PC never wraps, because no load happens at pc == NUM_INSTR.
- **Stall:** instr, instr_pc and instr_valid hold stable while instr_valid=1 and instr_ready=0.

## Timing
- **Reset values:** state=IDLE, pc=0 (rom_address=0), instr=0, instr_pc=0, instr_valid=0, busy=0, done=0, stall_cycles=0.
- **Reset assertion:** reset_n low forces all reset values immediately, without waiting for a clock edge, including mid-FETCH.
- **Start latency:** start high at edge E0 -> FETCH and rom_address=0 after E0 -> instr=ROM[0], instr_valid=1, rom_address=1 after E1.
- **Throughput:** one instruction per cycle while instr_ready=1.
- **Branch timing:** branch_en at edge Eb -> instr_valid=0 after Eb -> instr=ROM[target] valid after Eb+1. This is a one-bubble penalty.
- **End-of-program timing:** with ready held high, the last instruction (instr_pc=NUM_INSTR-1) is accepted at edge Ek. busy=0, done=1 and instr_valid=0 after Ek.
- **Combinational paths:** none from inputs to outputs.

## Configuration
- **FETCH_STALL_COUNT_EN defined:**
  - Adds output stall_cycles (out, 16 bits).
  - It increments on each FETCH cycle with instr_valid=1 && instr_ready=0.
  - It saturates at 16'hFFFF.
  - It clears to 0 on reset and on the cycle start is accepted.
- **FETCH_STALL_COUNT_EN undefined:** the port and the counter are absent; all other behaviour is identical.

## Test plan
- **Straight-line run:** reset, start pulse, instr_ready=1 -> instr_valid high on the second edge after start; instr_pc sequence 0..65 on consecutive cycles, instr matching ROM; done=1 the cycle after instr_pc=65 is accepted.
- **Backpressure:** instr_ready=0 for 5 cycles while instr_pc=10 -> instr, instr_pc=10 and instr_valid held stable; rom_address=11; no skipped or duplicated pc. With FETCH_STALL_COUNT_EN, stall_cycles=5.
- **Branch:** branch_en with branch_target=3 while instr_pc=20 and ready=1 -> one bubble (instr_valid=0), then instr_pc=3,4,5...
- **Branch out of range:** branch_target=100 -> instr_valid=0 and done=1 after the next edge. A later start pulse restarts at instr_pc=0.
- **Mid-run reset:** reset_n low asynchronously at instr_pc=30 -> all outputs at reset values before the next clock edge. start is ignored during FETCH: no pc change.
